// File: rtl/cdc_sync_filt.sv
// Multi-bit level synchronizer. Each bit has its own flop chain, an optional
// stability filter and registered rise/fall pulses.
module cdc_sync_filt #(
    parameter int               WIDTH         = 32,
    parameter int               STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               FILTER_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
);

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $fatal(1, "cdc_sync_filt: STAGES must be within 2..8");
    end
    if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filter
        $fatal(1, "cdc_sync_filt: FILTER_CYCLES must be within 0..255");
    end

    // Metastability chain: flop-to-flop only, kept together and never retimed.
    (* ASYNC_REG = "TRUE", DONT_RETIME = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= RESET_VAL;
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[STAGES-1];

    if (FILTER_CYCLES == 0) begin : g_nofilt
        // The last chain stage is the output; pulses look one stage ahead so
        // they line up with the cycle data_o changes.
        assign data_o = s;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rise_o <= '0;
                fall_o <= '0;
            end else begin
                rise_o <=  sync_q[STAGES-2] & ~s;
                fall_o <= ~sync_q[STAGES-2] &  s;
            end
        end
    end else begin : g_filt
        localparam int            CW       = $clog2(FILTER_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
        localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER_CYCLES);

        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] mism;
        logic [WIDTH-1:0] hit;
        logic [CW-1:0]    cnt_q [WIDTH];

        assign mism = s ^ data_q;

        // hit: this edge completes N consecutive mismatching cycles.
        always_comb begin
            hit = '0;
            for (int i = 0; i < WIDTH; i++) begin
                hit[i] = mism[i] && (cnt_q[i] == CNT_LAST);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= RESET_VAL;
                rise_o <= '0;
                fall_o <= '0;
                for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            end else begin
                data_q <= data_q ^ hit;
                rise_o <= hit &  s;
                fall_o <= hit & ~s;
                for (int i = 0; i < WIDTH; i++) begin
                    if (!mism[i] || hit[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end
            end
        end

        assign data_o = data_q;
    end

    assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_cdc_sync_filt.sv
// Bench for cdc_sync_filt: three 4-bit configurations checked against a
// history-based model every cycle, plus vector tables and corner sequences.
module tb_cdc_sync_filt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din_a = '0, din_b = '0, din_c = 4'hF;
    logic [3:0] data_a, rise_a, fall_a, data_b, rise_b, fall_b, data_c, rise_c, fall_c;
    logic       chg_a, chg_b, chg_c;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    cdc_sync_filt #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'h0), .FILTER_CYCLES(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .data_i(din_a), .data_o(data_a),
        .rise_o(rise_a), .fall_o(fall_a), .changed_o(chg_a));
    cdc_sync_filt #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'h0), .FILTER_CYCLES(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .data_i(din_b), .data_o(data_b),
        .rise_o(rise_b), .fall_o(fall_b), .changed_o(chg_b));
    cdc_sync_filt #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'hF), .FILTER_CYCLES(2)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .data_i(din_c), .data_o(data_c),
        .rise_o(rise_c), .fall_o(fall_c), .changed_o(chg_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // data_i history per instance; s(t-k) is the input sampled STAGES-1+k edges ago.
    logic [3:0] hist [3][16];
    int         n_hist [3];
    logic [3:0] m_o [3], m_r [3], m_f [3];

    function automatic int stg(input int m);
        return (m == 1) ? 3 : 2;
    endfunction
    function automatic int flt(input int m);
        return (m == 0) ? 0 : ((m == 1) ? 3 : 2);
    endfunction
    function automatic logic [3:0] rv(input int m);
        return (m == 2) ? 4'hF : 4'h0;
    endfunction
    function automatic logic [3:0] din_of(input int m);
        return (m == 0) ? din_a : ((m == 1) ? din_b : din_c);
    endfunction
    function automatic logic [3:0] s_at(input int m, input int back);
        if (n_hist[m] >= stg(m) + back) return hist[m][stg(m) - 1 + back];
        return rv(m);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            n_hist[m] = 0;
            m_o[m] = rv(m);
            m_r[m] = '0;
            m_f[m] = '0;
        end
    endtask

    // A filtered bit takes the new level once the synchronized level has
    // disagreed with the output for N consecutive cycles.
    task automatic model_step();
        logic [3:0] old_v, new_v, sv;
        bit         all_diff;
        for (int m = 0; m < 3; m++) begin
            for (int j = 15; j > 0; j--) hist[m][j] = hist[m][j-1];
            hist[m][0] = din_of(m);
            if (n_hist[m] < 16) n_hist[m]++;
            old_v = m_o[m];
            if (flt(m) == 0) begin
                new_v = s_at(m, 0);
            end else begin
                new_v = old_v;
                for (int b = 0; b < 4; b++) begin
                    all_diff = 1'b1;
                    for (int i = 1; i <= flt(m); i++) begin
                        sv = s_at(m, i);
                        if (sv[b] == old_v[b]) all_diff = 1'b0;
                    end
                    if (all_diff) new_v[b] = ~old_v[b];
                end
            end
            m_o[m] = new_v;
            m_r[m] = new_v & ~old_v;
            m_f[m] = ~new_v & old_v;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
    end
    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_a_data", data_a, m_o[0]);
            chk("mdl_a_rise", rise_a, m_r[0]);
            chk("mdl_a_fall", fall_a, m_f[0]);
            chk("mdl_a_chg", chg_a, |(m_r[0] | m_f[0]));
            chk("mdl_b_data", data_b, m_o[1]);
            chk("mdl_b_rise", rise_b, m_r[1]);
            chk("mdl_b_fall", fall_b, m_f[1]);
            chk("mdl_b_chg", chg_b, |(m_r[1] | m_f[1]));
            chk("mdl_c_data", data_c, m_o[2]);
            chk("mdl_c_rise", rise_c, m_r[2]);
            chk("mdl_c_fall", fall_c, m_f[2]);
            chk("mdl_c_chg", chg_c, |(m_r[2] | m_f[2]));
        end
    end

    // ---------------- directed vectors for instance A ----------------
    typedef struct {
        logic [3:0] din;
        logic [3:0] exp_o;
        logic [3:0] exp_r;
        logic [3:0] exp_f;
        logic       exp_chg;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int         first_e, n_pulse, hi_seen, chg_seen;
        logic [3:0] fall_at;

        model_reset();
        chk_en = 1'b1;

        tbl[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1] = '{4'h5, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2] = '{4'h5, 4'h5, 4'h5, 4'h0, 1'b1};
        tbl[3] = '{4'h5, 4'h5, 4'h0, 4'h0, 1'b0};
        tbl[4] = '{4'hC, 4'h5, 4'h0, 4'h0, 1'b0};
        tbl[5] = '{4'hC, 4'hC, 4'h8, 4'h1, 1'b1};
        tbl[6] = '{4'hC, 4'hC, 4'h0, 4'h0, 1'b0};
        tbl[7] = '{4'h3, 4'hC, 4'h0, 4'h0, 1'b0};
        tbl[8] = '{4'h3, 4'h3, 4'h3, 4'hC, 1'b1};
        tbl[9] = '{4'h3, 4'h3, 4'h0, 4'h0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_data", data_a, 4'h0);
        chk("rst_b_data", data_b, 4'h0);
        chk("rst_c_data", data_c, 4'hF);
        chk("rst_pulses", {rise_a, fall_a, rise_b, fall_b, rise_c, fall_c}, 24'h0);
        chk("rst_chg", {chg_a, chg_b, chg_c}, 3'b000);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            din_a = tbl[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_data", i), data_a, tbl[i].exp_o);
            chk($sformatf("tbl%0d_rise", i), rise_a, tbl[i].exp_r);
            chk($sformatf("tbl%0d_fall", i), fall_a, tbl[i].exp_f);
            chk($sformatf("tbl%0d_chg", i), chg_a, tbl[i].exp_chg);
        end

        // Reset lands between edges with a 0->F change in flight on A; C sees 0 at release.
        @(negedge clk);
        din_a = 4'h0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        din_a = 4'hF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a_data", data_a, 4'h0);
        chk("midrst_a_rise", rise_a, 4'h0);
        chk("midrst_c_data", data_c, 4'hF);
        din_a = 4'h0;
        din_c = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        first_e = -1;
        n_pulse = 0;
        chg_seen = 0;
        hi_seen = 0;
        fall_at = '0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (chg_a) chg_seen++;
            if (data_a != 4'h0) hi_seen++;
            if (fall_c != 4'h0) n_pulse++;
            if (first_e < 0 && data_c == 4'h0) begin
                first_e = e;
                fall_at = fall_c;
            end
            if (e == 3) chk("relc_hold_e3", data_c, 4'hF);
        end
        chk("rela_no_pulse", chg_seen, 0);
        chk("rela_stays_rv", hi_seen, 0);
        chk("relc_latency", first_e, 4);
        chk("relc_fall_val", fall_at, 4'hF);
        chk("relc_fall_once", n_pulse, 1);

        // Instance B: two-cycle glitch must be filtered out.
        @(negedge clk);
        din_b = 4'h1;
        repeat (2) @(negedge clk);
        din_b = 4'h0;
        hi_seen = 0;
        chg_seen = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (data_b[0] || rise_b[0]) hi_seen++;
            if (chg_b) chg_seen++;
        end
        chk("glitch_data", hi_seen, 0);
        chk("glitch_chg", chg_seen, 0);

        // Instance B: held levels appear after STAGES+N = 6 edges.
        for (int lvl = 1; lvl >= 0; lvl--) begin
            @(negedge clk);
            din_b = (lvl == 1) ? 4'h1 : 4'h0;
            first_e = -1;
            n_pulse = 0;
            for (int e = 1; e <= 20; e++) begin
                @(posedge clk);
                #1;
                if (first_e < 0 && data_b[0] == lvl[0]) first_e = e;
                if (lvl == 1 ? rise_b[0] : fall_b[0]) begin
                    n_pulse++;
                    chk($sformatf("hold%0d_pulse_edge", lvl), e, 6);
                end
            end
            chk($sformatf("hold%0d_latency", lvl), first_e, 6);
            chk($sformatf("hold%0d_pulse_cnt", lvl), n_pulse, 1);
        end

        // Randomized levels with slow changes so filtered paths see both outcomes.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) din_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) din_b = din_b ^ (4'b1 << $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) din_c = 4'($urandom_range(0, 15));
            if (cyc == 300) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_sync_filt.md
CDC_SYNC_FILT -- requirements
Module: cdc_sync_filt

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, number of independent single-bit channels.
REQ-002 SHALL provide parameter STAGES, default 2, synchronizer flop depth, legal range 2..8.
REQ-003 SHALL provide parameter RESET_VAL, default 0, WIDTH-bit reset value of the synchronizer chain and data_o.
REQ-004 SHALL provide parameter FILTER_CYCLES, default 0, per-channel stability count; 0 disables the filter; legal range 0..255.
REQ-005 SHALL have port clk_i, input, 1 bit: the single destination clock; all flops are rising-edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port data_i, input, WIDTH bits: asynchronous source levels.
REQ-008 SHALL have port data_o, output, WIDTH bits: synchronized and filtered levels, registered.
REQ-009 SHALL have port rise_o, output, WIDTH bits: per-channel one-cycle 0->1 pulse, registered.
REQ-010 SHALL have port fall_o, output, WIDTH bits: per-channel one-cycle 1->0 pulse, registered.
REQ-011 SHALL have port changed_o, output, 1 bit: OR-reduction of rise_o | fall_o.

Function
REQ-012 SHALL sample data_i into a STAGES-deep flop chain per bit; the last stage is s, with no logic between stages.
REQ-013 SHALL, with FILTER_CYCLES=0, drive data_o from the last chain stage, giving a latency of exactly STAGES rising edges from data_i to data_o.
REQ-014 SHALL, with FILTER_CYCLES=N>0, keep a per-channel counter of width clog2(N+1) that clears whenever s[i]==data_o[i].
REQ-015 SHALL, with FILTER_CYCLES=N>0, increment counter[i] each cycle s[i]!=data_o[i], saturating at N.
REQ-016 SHALL update data_o[i]<=s[i] and clear counter[i] on the edge where counter[i]==N-1 and s[i]!=data_o[i], so a held level propagates after exactly STAGES+N edges.
REQ-017 SHALL discard any s[i] excursion shorter than N consecutive cycles, leaving data_o[i] and the edge pulses unaffected.
REQ-018 SHALL assert rise_o[i] (fall_o[i]) for exactly the one cycle in which data_o[i] first shows 1 (0) after showing 0 (1).
REQ-019 SHALL process channels independently; simultaneous changes on multiple bits produce simultaneous pulses.
REQ-020 SHALL derive changed_o combinationally from the registered rise_o/fall_o only.
REQ-021 SHALL reject STAGES<2 or STAGES>8 and FILTER_CYCLES>255 at elaboration with a fatal error.
REQ-022 SHALL tag chain flops for synthesis as asynchronous-register/no-retime.

Reset
REQ-023 SHALL, while rst_ni=0, force all chain stages and data_o to RESET_VAL, counters to 0, and rise_o/fall_o/changed_o to 0, independent of clk_i.
REQ-024 SHALL, when reset is asserted mid-propagation or mid-filter, discard all in-flight values with no pulse emitted.
REQ-025 SHALL, after reset release with data_i!=RESET_VAL, treat the difference as a normal change: data_o updates after the standard latency with the matching pulse.

Verification
REQ-026 SHALL cover: WIDTH=4, STAGES=2, FILTER=0; data_i 0x0->0x5 before edge k -> data_o=0x5 and rise_o=0x5 from edge k+1, rise_o=0 at k+2, changed_o=1 for one cycle.
REQ-027 SHALL cover: STAGES=3, FILTER=3; data_i[0] high for exactly 2 cycles -> data_o, rise_o, changed_o stay 0.
REQ-028 SHALL cover: STAGES=3, FILTER=3; data_i[0] high and held -> data_o[0]=1 exactly 6 edges later, rise_o[0] for one cycle; then held low -> fall_o[0] 6 edges later.
REQ-029 SHALL cover: RESET_VAL=0xF, WIDTH=4, data_i=0x0 at reset release -> data_o=0xF until latency expires, then 0x0 with fall_o=0xF for one cycle.
REQ-030 SHALL cover: rst_ni asserted between clock edges while a 0->1 change is in flight -> outputs return to RESET_VAL immediately, no pulse before or after release if data_i==RESET_VAL.
REQ-031 SHALL cover: data_i bits 0 and 3 toggle in the same cycle in opposite directions -> rise_o and fall_o pulse in the same cycle, changed_o=1 once.
